// File: rtl/spi_host_master.sv
// spi_host_master: host-side SPI mode-0 initiator issuing single 24-bit register/RAM frames
module spi_host_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [9:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_sclk,
    output logic       o_ssn,
    output logic       o_mosi,
    input  logic       i_miso
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0] HALF_LAST = 6'd47;
    localparam logic [5:0] GAP_LAST = 6'(CS_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [5:0]      r_half;
    logic [23:0]     r_tx;
    logic [7:0]      r_rx;
    logic            r_we;
    logic            r_sclk;
    logic            r_ssn;
    logic            r_busy;
    logic            r_done;
    logic [7:0]      r_rdata;

    state_t          w_state;
    logic [DW-1:0]   w_div;
    logic [5:0]      w_half;
    logic [23:0]     w_tx;
    logic [7:0]      w_rx;
    logic            w_we;
    logic            w_sclk;
    logic            w_ssn;
    logic            w_busy;
    logic            w_done;
    logic [7:0]      w_rdata;
    logic            w_div_last;
    logic [DW-1:0]   w_div_inc;
    logic [7:0]      w_wbyte;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_div_inc  = w_div_last ? '0 : r_div + DW'(1);
    assign w_wbyte    = i_we ? i_wdata : 8'h00;

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;
    assign o_sclk  = r_sclk;
    assign o_ssn   = r_ssn;
    assign o_mosi  = r_tx[23];

    // State and output registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_half  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_we    <= 1'b0;
            r_sclk  <= 1'b0;
            r_ssn   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_half  <= w_half;
            r_tx    <= w_tx;
            r_rx    <= w_rx;
            r_we    <= w_we;
            r_sclk  <= w_sclk;
            r_ssn   <= w_ssn;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_rdata <= w_rdata;
        end
    end

    // Next state and next register values; MOSI is the shifter MSB so it reads 0 whenever the shifter is empty
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_half  = r_half;
        w_tx    = r_tx;
        w_rx    = r_rx;
        w_we    = r_we;
        w_sclk  = r_sclk;
        w_ssn   = r_ssn;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_rdata = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_state = S_SETUP;
                    w_div   = '0;
                    w_half  = '0;
                    w_tx    = {i_we, 5'b0, i_addr, w_wbyte};
                    w_we    = i_we;
                    w_ssn   = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            S_SETUP: begin
                w_div = w_div_inc;
                if (w_div_last) begin
                    w_state = S_SHIFT;
                    w_sclk  = 1'b1;
                    w_rx    = {r_rx[6:0], i_miso};
                end
            end
            S_SHIFT: begin
                w_div = w_div_inc;
                if (w_div_last) begin
                    if (r_half == HALF_LAST) begin
                        w_state = S_HOLD;
                        w_sclk  = 1'b0;
                    end else begin
                        w_half = r_half + 6'd1;
                        w_sclk = ~r_sclk;
                        if (r_sclk)
                            w_tx = {r_tx[22:0], 1'b0};
                        else
                            w_rx = {r_rx[6:0], i_miso};
                    end
                end
            end
            S_HOLD: begin
                w_div = w_div_inc;
                if (w_div_last) begin
                    w_state = S_GAP;
                    w_half  = '0;
                    w_tx    = '0;
                    w_ssn   = 1'b1;
                    w_done  = 1'b1;
                    w_rdata = r_we ? r_rdata : r_rx;
                end
            end
            S_GAP: begin
                w_div = w_div_inc;
                if (w_div_last) begin
                    if (r_half == GAP_LAST) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                    end else begin
                        w_half = r_half + 6'd1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_div   = '0;
                w_tx    = '0;
                w_sclk  = 1'b0;
                w_ssn   = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end
endmodule
